// File: rtl/mem_port_arbiter_if.sv
`timescale 1ns/1ps
// mem_port_arbiter_if: fetch-side, data-side and memory-side signals of the shared memory port.
// Latency: none, signal bundle only.
// Backpressure: requesters hold Req until Valid; memory completes a request with MemReady.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic                  IReq;
  logic [ADDR_W-1:0]     IAddr;
  logic [DATA_W-1:0]     IRData;
  logic                  IValid;
  logic                  DReq;
  logic                  DWe;
  logic [ADDR_W-1:0]     DAddr;
  logic [DATA_W-1:0]     DWData;
  logic [DATA_W/8-1:0]   DBe;
  logic [DATA_W-1:0]     DRData;
  logic                  DValid;
  logic                  StallIF;
  logic                  StallMem;
  logic                  MemReq;
  logic                  MemWe;
  logic [ADDR_W-1:0]     MemAddr;
  logic [DATA_W-1:0]     MemWData;
  logic [DATA_W/8-1:0]   MemBe;
  logic [DATA_W-1:0]     MemRData;
  logic                  MemReady;

  // Arbiter view: takes requests and memory responses, drives completions and the memory request.
  modport slave (
    input  IReq, IAddr, DReq, DWe, DAddr, DWData, DBe, MemRData, MemReady,
    output IRData, IValid, DRData, DValid, StallIF, StallMem,
           MemReq, MemWe, MemAddr, MemWData, MemBe
  );

  // Environment view: pipeline requesters plus the memory model.
  modport master (
    output IReq, IAddr, DReq, DWe, DAddr, DWData, DBe, MemRData, MemReady,
    input  IRData, IValid, DRData, DValid, StallIF, StallMem,
           MemReq, MemWe, MemAddr, MemWData, MemBe
  );
endinterface

// File: rtl/mem_port_arbiter.sv
`timescale 1ns/1ps
// mem_port_arbiter: one single-port memory shared by fetch (I) and memory stage (D), data-first with alternation; MEMARB_IBUF_EN adds a one-entry fetch buffer.
// Latency: Req seen in IDLE at t -> MemReq at t+1; MemReady at t+k -> Valid at t+k+1 (fetch-buffer hit: Valid at t+1).
// Backpressure: requesters hold Req and see StallIF/StallMem until their Valid pulse; memory stretches an access by holding MemReady low.
module mem_port_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  mem_port_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, IBUSY, DBUSY} state_t;

  state_t state;
  logic   lastGrantD;
  logic   iElig;
  logic   dElig;
  logic   grantD;
  logic   grantI;

  // A side pulsing Valid still shows Req this cycle; masking it stops a finished access from being re-issued.
  assign iElig = bus.IReq & ~bus.IValid;
  assign dElig = bus.DReq & ~bus.DValid;

  // Data wins ties unless it also won the previous grant, so a fetch waits behind at most one data access.
  assign grantD = (state == IDLE) & dElig & ~(iElig & lastGrantD);
  assign grantI = (state == IDLE) & iElig & ~grantD;

  assign bus.StallIF  = bus.IReq & ~bus.IValid;
  assign bus.StallMem = bus.DReq & ~bus.DValid;

`ifdef MEMARB_IBUF_EN
  logic              bufValid;
  logic [ADDR_W-1:0] bufAddr;
  logic [DATA_W-1:0] bufData;
  logic              bufHit;

  assign bufHit = bufValid & (bus.IAddr == bufAddr);

  // Remember the last fetched word; a granted store to that word makes the copy stale.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bufValid <= 1'b0;
      bufAddr  <= {ADDR_W{1'b0}};
      bufData  <= {DATA_W{1'b0}};
    end else if (state == IBUSY && bus.MemReady) begin
      bufValid <= 1'b1;
      bufAddr  <= bus.MemAddr;
      bufData  <= bus.MemRData;
    end else if (grantD && bus.DWe && (bus.DAddr[ADDR_W-1:2] == bufAddr[ADDR_W-1:2])) begin
      bufValid <= 1'b0;
    end
  end
`endif

  // Grant/complete FSM; every output it owns is a register, and Valid pulses last exactly one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      lastGrantD   <= 1'b0;
      bus.MemReq   <= 1'b0;
      bus.MemWe    <= 1'b0;
      bus.MemAddr  <= {ADDR_W{1'b0}};
      bus.MemWData <= {DATA_W{1'b0}};
      bus.MemBe    <= {(DATA_W/8){1'b0}};
      bus.IRData   <= {DATA_W{1'b0}};
      bus.IValid   <= 1'b0;
      bus.DRData   <= {DATA_W{1'b0}};
      bus.DValid   <= 1'b0;
    end else begin
      bus.IValid <= 1'b0;
      bus.DValid <= 1'b0;
      case (state)
        IDLE: begin
          if (grantD) begin
            state        <= DBUSY;
            lastGrantD   <= 1'b1;
            bus.MemReq   <= 1'b1;
            bus.MemWe    <= bus.DWe;
            bus.MemAddr  <= bus.DAddr;
            bus.MemWData <= bus.DWData;
            bus.MemBe    <= bus.DBe;
          end else if (grantI) begin
`ifdef MEMARB_IBUF_EN
            if (bufHit) begin
              // Served locally: no memory access, arbitration history untouched.
              bus.IRData <= bufData;
              bus.IValid <= 1'b1;
            end else begin
`endif
              state        <= IBUSY;
              lastGrantD   <= 1'b0;
              bus.MemReq   <= 1'b1;
              bus.MemWe    <= 1'b0;
              bus.MemAddr  <= bus.IAddr;
              bus.MemWData <= {DATA_W{1'b0}};
              bus.MemBe    <= {(DATA_W/8){1'b0}};
`ifdef MEMARB_IBUF_EN
            end
`endif
          end
        end
        IBUSY: begin
          if (bus.MemReady) begin
            state      <= IDLE;
            bus.MemReq <= 1'b0;
            bus.IRData <= bus.MemRData;
            bus.IValid <= 1'b1;
          end
        end
        DBUSY: begin
          if (bus.MemReady) begin
            state      <= IDLE;
            bus.MemReq <= 1'b0;
            if (!bus.MemWe) begin
              bus.DRData <= bus.MemRData;
            end
            bus.DValid <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
`timescale 1ns/1ps
// tb_mem_port_arbiter: directed scenarios plus randomized I/D traffic against a transaction-level model.
// Latency: model predicts every output cycle by cycle from the arbitration rules.
// Backpressure: memory model stretches accesses with random MemReady latency.
module tb_mem_port_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
`ifdef MEMARB_IBUF_EN
  localparam bit IBUF = 1'b1;
`else
  localparam bit IBUF = 1'b0;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int totalCnt = 0;
  int passCnt  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    totalCnt++;
    if (act === exp) passCnt++;
    else $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
  endtask

  // ---------------- backing memory (word addressed, random fill on first touch)
  logic [31:0] mem [logic [29:0]];

  function automatic logic [31:0] memRd(input logic [31:0] a);
    if (!mem.exists(a[31:2])) mem[a[31:2]] = $urandom;
    return mem[a[31:2]];
  endfunction

  task automatic memWr(input logic [31:0] a, input logic [31:0] v);
    mem[a[31:2]] = v;
  endtask

  // ---------------- memory responder: MemReady after 'lat' extra cycles, noise while idle
  int latCfg = 0;
  int lat    = 0;
  int cnt    = 0;
  initial begin
    bus.MemReady = 1'b0;
    bus.MemRData = '0;
    forever begin
      @(posedge clk); #1;
      if (rst_n && bus.MemReq) begin
        if (cnt == lat) begin
          bus.MemReady = 1'b1;
          bus.MemRData = bus.MemWe ? $urandom : memRd(bus.MemAddr);
        end else begin
          bus.MemReady = 1'b0;
          bus.MemRData = $urandom;
        end
        cnt++;
      end else begin
        bus.MemReady = 1'($urandom_range(0, 1));
        bus.MemRData = $urandom;
        cnt = 0;
        lat = (latCfg < 0) ? int'($urandom_range(0, 3)) : latCfg;
      end
    end
  end

  // ---------------- random requesters (active only in the random phase)
  bit randOn = 1'b0;
  initial begin
    forever begin
      @(posedge clk); #1;
      if (randOn) begin
        if (bus.IReq && bus.IValid) begin
          if ($urandom_range(0, 1) == 1) bus.IAddr = 32'h100 + 4 * $urandom_range(0, 3);
          else bus.IReq = 1'b0;
        end else if (!bus.IReq && $urandom_range(0, 2) == 0) begin
          bus.IReq  = 1'b1;
          bus.IAddr = 32'h100 + 4 * $urandom_range(0, 3);
        end
        if ((bus.DReq && bus.DValid) || (!bus.DReq && $urandom_range(0, 2) == 0)) begin
          bus.DReq   = 1'($urandom_range(0, 1));
          bus.DWe    = 1'($urandom_range(0, 1));
          bus.DAddr  = 32'h100 + 4 * $urandom_range(0, 7);
          bus.DWData = $urandom;
          bus.DBe    = 4'($urandom_range(0, 15));
        end
      end
    end
  end

  // ---------------- transaction-level reference model (side 0 = fetch, side 1 = data)
  int          busySide;
  bit          lastWasD;
  bit          expValid [2];
  logic [31:0] expRData [2];
  bit          expMemReq, expMemWe;
  logic [31:0] expMemAddr, expMemWData;
  logic [3:0]  expMemBe;
  bit          bufV;
  logic [31:0] bufA, bufD;

  task automatic modelReset();
    busySide = -1; lastWasD = 1'b0;
    expValid[0] = 1'b0; expValid[1] = 1'b0;
    expRData[0] = '0;   expRData[1] = '0;
    expMemReq = 1'b0; expMemWe = 1'b0; expMemAddr = '0; expMemWData = '0; expMemBe = '0;
    bufV = 1'b0; bufA = '0; bufD = '0;
  endtask

  task automatic modelStep();
    bit          elig [2];
    bit          nv   [2];
    logic [31:0] w;
    elig[0] = bus.IReq && !expValid[0];
    elig[1] = bus.DReq && !expValid[1];
    nv[0] = 1'b0; nv[1] = 1'b0;
    if (busySide >= 0) begin
      if (bus.MemReady) begin
        if (busySide == 1 && expMemWe) begin
          w = memRd(expMemAddr);
          for (int b = 0; b < 4; b++) if (expMemBe[b]) w[8*b +: 8] = expMemWData[8*b +: 8];
          memWr(expMemAddr, w);
        end else begin
          expRData[busySide] = memRd(expMemAddr);
          if (busySide == 0) begin bufV = 1'b1; bufA = expMemAddr; bufD = expRData[0]; end
        end
        nv[busySide] = 1'b1;
        busySide  = -1;
        expMemReq = 1'b0;
      end
    end else if (elig[0] || elig[1]) begin
      if (elig[1] && !(elig[0] && lastWasD)) begin
        busySide = 1; lastWasD = 1'b1; expMemReq = 1'b1;
        expMemWe = bus.DWe; expMemAddr = bus.DAddr; expMemWData = bus.DWData; expMemBe = bus.DBe;
        if (bus.DWe && bufA[31:2] == bus.DAddr[31:2]) bufV = 1'b0;
      end else if (IBUF && bufV && bufA == bus.IAddr) begin
        expRData[0] = bufD;
        nv[0] = 1'b1;
      end else begin
        busySide = 0; lastWasD = 1'b0; expMemReq = 1'b1;
        expMemWe = 1'b0; expMemAddr = bus.IAddr; expMemBe = '0;
      end
    end
    expValid = nv;
  endtask

  initial begin
    modelReset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) modelReset();
      else modelStep();
    end
  end

  // ---------------- per-cycle comparison of every output against the model
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        check("IValid",   32'(bus.IValid),   32'(expValid[0]));
        check("DValid",   32'(bus.DValid),   32'(expValid[1]));
        check("IRData",   bus.IRData,        expRData[0]);
        check("DRData",   bus.DRData,        expRData[1]);
        check("MemReq",   32'(bus.MemReq),   32'(expMemReq));
        check("MemAddr",  bus.MemAddr,       expMemAddr);
        check("MemWe",    32'(bus.MemWe),    32'(expMemWe));
        check("MemBe",    32'(bus.MemBe),    32'(expMemBe));
        if (expMemWe) check("MemWData", bus.MemWData, expMemWData);
        check("StallIF",  32'(bus.StallIF),  32'(bus.IReq && !expValid[0]));
        check("StallMem", 32'(bus.StallMem), 32'(bus.DReq && !expValid[1]));
      end
    end
  end

  // ---------------- directed helpers (bounded waits)
  task automatic doFetch(input logic [31:0] a, output int cycles);
    cycles = 99;
    bus.IReq = 1'b1; bus.IAddr = a;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (bus.IValid) begin cycles = i; break; end
    end
    bus.IReq = 1'b0;
  endtask

  task automatic doData(input logic we, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] be, output int cycles);
    cycles = 99;
    bus.DReq = 1'b1; bus.DWe = we; bus.DAddr = a; bus.DWData = d; bus.DBe = be;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (bus.DValid) begin cycles = i; break; end
    end
    bus.DReq = 1'b0;
  endtask

  // ---------------- main sequence
  initial begin
    int c;
    bit got;
    bus.IReq = 1'b0; bus.IAddr = '0;
    bus.DReq = 1'b0; bus.DWe = 1'b0; bus.DAddr = '0; bus.DWData = '0; bus.DBe = '0;
    memWr(32'h100,  32'h00500093);
    memWr(32'h104,  32'h33334444);
    memWr(32'h2000, 32'h11112222);
    memWr(32'h2004, 32'hAABBCCDD);
    memWr(32'h2008, 32'h55556666);

    // reset state
    #1 rst_n = 1'b0;
    #2;
    check("rst_MemReq",  32'(bus.MemReq),  32'd0);
    check("rst_IValid",  32'(bus.IValid),  32'd0);
    check("rst_DValid",  32'(bus.DValid),  32'd0);
    check("rst_IRData",  bus.IRData,       32'd0);
    check("rst_DRData",  bus.DRData,       32'd0);
    check("rst_MemAddr", bus.MemAddr,      32'd0);
    check("rst_StallIF", 32'(bus.StallIF), 32'd0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;

    // single fetch, memory ready in first MemReq cycle
    bus.IReq = 1'b1; bus.IAddr = 32'h100;
    #1;
    check("f1_stall_t", 32'(bus.StallIF), 32'd1);
    check("f1_noreq_t", 32'(bus.MemReq),  32'd0);
    @(negedge clk);
    check("f1_memreq",  32'(bus.MemReq),  32'd1);
    check("f1_memaddr", bus.MemAddr,      32'h100);
    check("f1_stall_t1",32'(bus.StallIF), 32'd1);
    @(negedge clk);
    check("f1_ivalid",  32'(bus.IValid),  32'd1);
    check("f1_irdata",  bus.IRData,       32'h00500093);
    check("f1_stall_t2",32'(bus.StallIF), 32'd0);
    bus.IReq = 1'b0;

    // simultaneous requests: D first, then I, then the follow-on D request
    @(negedge clk);
    bus.IReq = 1'b1; bus.IAddr = 32'h104;
    bus.DReq = 1'b1; bus.DWe = 1'b0; bus.DAddr = 32'h2000;
    @(negedge clk);
    check("sim_d_addr",  bus.MemAddr,     32'h2000);
    check("sim_d_we",    32'(bus.MemWe),  32'd0);
    @(negedge clk);
    check("sim_dvalid",  32'(bus.DValid), 32'd1);
    check("sim_drdata",  bus.DRData,      32'h11112222);
    check("sim_i_wait",  32'(bus.IValid), 32'd0);
    bus.DAddr = 32'h2008;
    @(negedge clk);
    check("sim_i_addr",  bus.MemAddr,     32'h104);
    @(negedge clk);
    check("sim_ivalid",  32'(bus.IValid), 32'd1);
    check("sim_irdata",  bus.IRData,      32'h33334444);
    bus.IReq = 1'b0;
    @(negedge clk);
    check("sim_d2_addr", bus.MemAddr,     32'h2008);
    check("sim_d2_req",  32'(bus.MemReq), 32'd1);
    @(negedge clk);
    check("sim_d2_valid",32'(bus.DValid), 32'd1);
    check("sim_d2_data", bus.DRData,      32'h55556666);
    bus.DReq = 1'b0;
    latCfg = 2;

    // store with a 3-cycle memory
    @(negedge clk);
    bus.DReq = 1'b1; bus.DWe = 1'b1; bus.DAddr = 32'h2004; bus.DWData = 32'hDEADBEEF; bus.DBe = 4'b0011;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("st_memreq", 32'(bus.MemReq), 32'd1);
      check("st_addr",   bus.MemAddr,     32'h2004);
      check("st_wdata",  bus.MemWData,    32'hDEADBEEF);
      check("st_be",     32'(bus.MemBe),  32'h3);
      check("st_we",     32'(bus.MemWe),  32'd1);
      check("st_nodv",   32'(bus.DValid), 32'd0);
    end
    @(negedge clk);
    check("st_dvalid",  32'(bus.DValid), 32'd1);
    check("st_drdata",  bus.DRData,      32'h55556666);
    check("st_reqdrop", 32'(bus.MemReq), 32'd0);
    bus.DReq = 1'b0;
    latCfg = 0;
    @(negedge clk);
    doData(1'b0, 32'h2004, 32'h0, 4'h0, c);
    check("st_readback_lat",  32'(c),     32'd2);
    check("st_readback_data", bus.DRData, 32'hAABBBEEF);

    // reset in the middle of a data access
    latCfg = 3;
    @(negedge clk);
    bus.DReq = 1'b1; bus.DWe = 1'b0; bus.DAddr = 32'h2010;
    @(negedge clk);
    check("rm_memreq", 32'(bus.MemReq), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("rm_memreq_clr", 32'(bus.MemReq), 32'd0);
    check("rm_dvalid_clr", 32'(bus.DValid), 32'd0);
    check("rm_drdata_clr", bus.DRData,      32'd0);
    check("rm_addr_clr",   bus.MemAddr,     32'd0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rm_reissue_req",  32'(bus.MemReq), 32'd1);
    check("rm_reissue_addr", bus.MemAddr,     32'h2010);
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge clk);
      if (bus.DValid) got = 1'b1;
    end
    check("rm_reissue_done", 32'(got), 32'd1);
    bus.DReq = 1'b0;
    latCfg = 0;

    // repeated fetch, store to the same word, fetch again
    @(negedge clk);
    doFetch(32'h100, c);
    check("ib_f1_lat",  32'(c),     32'd2);
    @(negedge clk);
    doFetch(32'h100, c);
    check("ib_f2_lat",  32'(c),     IBUF ? 32'd1 : 32'd2);
    check("ib_f2_data", bus.IRData, 32'h00500093);
    @(negedge clk);
    doData(1'b1, 32'h100, 32'h12345678, 4'hF, c);
    check("ib_st_lat",  32'(c),     32'd2);
    @(negedge clk);
    doFetch(32'h100, c);
    check("ib_f3_lat",  32'(c),     32'd2);
    check("ib_f3_data", bus.IRData, 32'h12345678);

    // randomized traffic against the model
    @(negedge clk);
    latCfg = -1;
    randOn = 1'b1;
    repeat (3000) @(negedge clk);
    randOn = 1'b0;

    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end
endmodule
